// File: rtl/sparc_exu_ecc_pipe_if.sv
// ---------------------------------------------------------------------------
// sparc_exu_ecc_pipe_if
//   Bundles the op-side and result-side handshakes of the EXU SEC-DED engine.
//
//   Op side     : in_vld, in_rdy, in_mode (0=GEN, 1=CHK), in_data, in_chk,
//                 in_msk (XOR mask for generated check bits), in_tag
//   Result side : out_vld, out_rdy, out_chk (GEN: masked check bits,
//                 CHK: syndrome), out_ce, out_ue, out_tag
//
//   Modports
//     master : the producer of ops and the consumer of results (testbench / EXU)
//     slave  : the engine itself
// ---------------------------------------------------------------------------
interface sparc_exu_ecc_pipe_if #(
    parameter int DATA_W = 64,
    parameter int CHK_W  = 8,
    parameter int TAG_W  = 6
);
    logic              in_vld;
    logic              in_rdy;
    logic              in_mode;
    logic [DATA_W-1:0] in_data;
    logic [CHK_W-1:0]  in_chk;
    logic [CHK_W-1:0]  in_msk;
    logic [TAG_W-1:0]  in_tag;

    logic              out_vld;
    logic              out_rdy;
    logic [CHK_W-1:0]  out_chk;
    logic              out_ce;
    logic              out_ue;
    logic [TAG_W-1:0]  out_tag;

    modport master (
        output in_vld, in_mode, in_data, in_chk, in_msk, in_tag, out_rdy,
        input  in_rdy, out_vld, out_chk, out_ce, out_ue, out_tag
    );

    modport slave (
        input  in_vld, in_mode, in_data, in_chk, in_msk, in_tag, out_rdy,
        output in_rdy, out_vld, out_chk, out_ce, out_ue, out_tag
    );
endinterface

// File: rtl/sparc_exu_ecc_pipe.sv
// ---------------------------------------------------------------------------
// sparc_exu_ecc_pipe
//   Pipelined SEC-DED generator / checker for EXU register-file and bypass
//   data. GEN mode produces CHK_W check bits (XORed with a per-op mask for
//   error injection); CHK mode recomputes them against the received bits and
//   reports the syndrome with correctable / uncorrectable flags.
//
//   Ports
//     clk    : clock
//     rst_l  : synchronous active-low reset
//     se     : scan enable, functionally inert
//     bus    : sparc_exu_ecc_pipe_if.slave (op and result handshakes)
//
//   Handshake: a transfer happens on a rising edge where both vld and rdy are
//   high; vld never depends on rdy, in_rdy depends combinationally only on
//   pipeline state and out_rdy, and a presented result (out_*) stays stable
//   until it is taken.
//
//   STAGES=2 : stage 1 registers per-group partial XORs; the output stage
//              reduces them and registers the result.
//   STAGES=1 : the output stage computes everything from the op directly.
// ---------------------------------------------------------------------------
module sparc_exu_ecc_pipe #(
    parameter int DATA_W = 64,
    parameter int CHK_W  = 8,
    parameter int STAGES = 2,
    parameter int GRP_W  = 8,
    parameter int TAG_W  = 6
) (
    input  logic                 clk,
    input  logic                 rst_l,
    input  logic                 se,
    sparc_exu_ecc_pipe_if.slave  bus
);
    localparam int LW = CHK_W - 1;                     // Hamming (low) check bits
    localparam int NG = (DATA_W + GRP_W - 1) / GRP_W;  // partial-XOR groups

    // Codeword position of data bit i: the i-th integer >= 3 that is not a
    // power of two (powers of two are the check-bit slots).
    function automatic int pos_of(input int i);
        int n;
        int r;
        n = 0;
        r = 0;
        for (int p = 3; p < (1 << CHK_W); p++) begin
            if ((p & (p - 1)) != 0) begin
                if (n == i) r = p;
                n++;
            end
        end
        return r;
    endfunction

    // Data bits that feed low check bit j.
    function automatic logic [DATA_W-1:0] col_mask(input int j);
        logic [DATA_W-1:0] m;
        for (int i = 0; i < DATA_W; i++) m[i] = ((pos_of(i) >> j) & 1) != 0;
        return m;
    endfunction

    // Data bits belonging to partial-XOR group g.
    function automatic logic [DATA_W-1:0] grp_mask(input int g);
        logic [DATA_W-1:0] m;
        for (int i = 0; i < DATA_W; i++) m[i] = (i / GRP_W) == g;
        return m;
    endfunction

    // Scan enable has no functional role in this block.
    logic unused_se;
    assign unused_se = se;

    // ---------------------------------------------------------------------
    // Front end: partial XORs of the incoming data word
    // ---------------------------------------------------------------------
    logic [LW-1:0][NG-1:0] f_part;
    logic [NG-1:0]         f_par;

    for (genvar j = 0; j < LW; j++) begin : g_col
        localparam logic [DATA_W-1:0] CMASK = col_mask(j);
        for (genvar g = 0; g < NG; g++) begin : g_grp
            localparam logic [DATA_W-1:0] GMASK = grp_mask(g);
            assign f_part[j][g] = ^(bus.in_data & CMASK & GMASK);
        end
    end

    for (genvar g = 0; g < NG; g++) begin : g_par
        localparam logic [DATA_W-1:0] PMASK = grp_mask(g);
        assign f_par[g] = ^(bus.in_data & PMASK);
    end

    // ---------------------------------------------------------------------
    // Payload seen by the output stage, and pipeline control
    // ---------------------------------------------------------------------
    logic [LW-1:0][NG-1:0] b_part;
    logic [NG-1:0]         b_par;
    logic                  b_mode;
    logic [CHK_W-1:0]      b_chk;
    logic [CHK_W-1:0]      b_msk;
    logic [TAG_W-1:0]      b_tag;
    logic                  src_vld;   // output stage has something to load
    logic                  in_rdy_c;
    logic                  out_ld;    // output register empty or being taken

    logic                  out_vld_q;
    logic [CHK_W-1:0]      out_chk_q;
    logic                  out_ce_q;
    logic                  out_ue_q;
    logic [TAG_W-1:0]      out_tag_q;

    assign out_ld = ~out_vld_q | bus.out_rdy;

    if (STAGES == 2) begin : g_two
        logic                  s1_vld;
        logic                  s1_adv;
        logic [LW-1:0][NG-1:0] s1_part;
        logic [NG-1:0]         s1_par;
        logic                  s1_mode;
        logic [CHK_W-1:0]      s1_chk;
        logic [CHK_W-1:0]      s1_msk;
        logic [TAG_W-1:0]      s1_tag;

        assign s1_adv   = s1_vld & out_ld;
        assign in_rdy_c = ~s1_vld | s1_adv;

        always_ff @(posedge clk) begin
            if (!rst_l) begin
                s1_vld  <= 1'b0;
                s1_part <= '0;
                s1_par  <= '0;
                s1_mode <= 1'b0;
                s1_chk  <= '0;
                s1_msk  <= '0;
                s1_tag  <= '0;
            end else if (in_rdy_c) begin
                s1_vld <= bus.in_vld;
                if (bus.in_vld) begin
                    s1_part <= f_part;
                    s1_par  <= f_par;
                    s1_mode <= bus.in_mode;
                    s1_chk  <= bus.in_chk;
                    s1_msk  <= bus.in_msk;
                    s1_tag  <= bus.in_tag;
                end
            end
        end

        assign src_vld = s1_vld;
        assign b_part  = s1_part;
        assign b_par   = s1_par;
        assign b_mode  = s1_mode;
        assign b_chk   = s1_chk;
        assign b_msk   = s1_msk;
        assign b_tag   = s1_tag;
    end else begin : g_one
        // The output register is the only stage, so it is the accepting one.
        assign in_rdy_c = out_ld;
        assign src_vld  = bus.in_vld;
        assign b_part   = f_part;
        assign b_par    = f_par;
        assign b_mode   = bus.in_mode;
        assign b_chk    = bus.in_chk;
        assign b_msk    = bus.in_msk;
        assign b_tag    = bus.in_tag;
    end

    // ---------------------------------------------------------------------
    // Reduce and decode
    // ---------------------------------------------------------------------
    logic [LW-1:0]    g_low;
    logic [LW-1:0]    s_low;
    logic             dpar;
    logic             s_top;
    logic [CHK_W-1:0] r_chk;
    logic             r_ce;
    logic             r_ue;

    always_comb begin
        g_low = '0;
        for (int j = 0; j < LW; j++) g_low[j] = ^b_part[j];
        dpar  = ^b_par;
        s_low = '0;
        s_top = 1'b0;
        r_chk = '0;
        r_ce  = 1'b0;
        r_ue  = 1'b0;
        if (b_mode) begin
            // Overall-parity bit of the syndrome spans data and every received
            // check bit, so a single flip anywhere sets it.
            s_low = g_low ^ b_chk[LW-1:0];
            s_top = dpar ^ (^b_chk);
            r_chk = {s_top, s_low};
            r_ce  = s_top;
            r_ue  = ~s_top & (|s_low);
        end else begin
            r_chk = {dpar ^ (^g_low), g_low} ^ b_msk;
        end
    end

    // ---------------------------------------------------------------------
    // Output register: loads only when empty or being consumed, so a stalled
    // result holds its value.
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_l) begin
            out_vld_q <= 1'b0;
            out_chk_q <= '0;
            out_ce_q  <= 1'b0;
            out_ue_q  <= 1'b0;
            out_tag_q <= '0;
        end else if (out_ld) begin
            out_vld_q <= src_vld;
            if (src_vld) begin
                out_chk_q <= r_chk;
                out_ce_q  <= r_ce;
                out_ue_q  <= r_ue;
                out_tag_q <= b_tag;
            end
        end
    end

    assign bus.in_rdy  = in_rdy_c;
    assign bus.out_vld = out_vld_q;
    assign bus.out_chk = out_chk_q;
    assign bus.out_ce  = out_ce_q;
    assign bus.out_ue  = out_ue_q;
    assign bus.out_tag = out_tag_q;
endmodule

// File: tb/tb_sparc_exu_ecc_pipe.sv
// ---------------------------------------------------------------------------
// tb_sparc_exu_ecc_pipe
//   Drives two engines side by side:
//     dut_a : DATA_W=64, CHK_W=8, STAGES=2
//     dut_b : DATA_W=32, CHK_W=7, STAGES=1 (random traffic and stalls)
//   Expected results come from a Hamming-position reference model and from
//   known check-bit values for DATA_W=64.
// ---------------------------------------------------------------------------
module tb_sparc_exu_ecc_pipe;
    logic clk;
    logic rst_l;
    logic se;

    sparc_exu_ecc_pipe_if #(.DATA_W(64), .CHK_W(8), .TAG_W(6)) bus_a ();
    sparc_exu_ecc_pipe_if #(.DATA_W(32), .CHK_W(7), .TAG_W(6)) bus_b ();

    sparc_exu_ecc_pipe #(.DATA_W(64), .CHK_W(8), .STAGES(2), .GRP_W(8), .TAG_W(6)) dut_a (
        .clk   (clk),
        .rst_l (rst_l),
        .se    (se),
        .bus   (bus_a.slave)
    );

    sparc_exu_ecc_pipe #(.DATA_W(32), .CHK_W(7), .STAGES(1), .GRP_W(8), .TAG_W(6)) dut_b (
        .clk   (clk),
        .rst_l (rst_l),
        .se    (se),
        .bus   (bus_b.slave)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    logic [15:0] exp_a_q[$];
    logic [15:0] exp_b_q[$];
    int          n_chk;
    int          n_pass;
    logic        a_acc;
    logic        a_hold;
    logic        b_hold;
    logic [15:0] a_prev;
    logic [15:0] b_prev;
    logic        use_dir;
    logic [9:0]  dir_exp;
    logic        b_auto;

    // Reference: low check bits are the XOR of the codeword positions of all
    // set data bits; the top bit is overall parity. Returns {ce, ue, bits}.
    function automatic logic [9:0] ref_ecc(input logic mode, input logic [63:0] data,
                                           input logic [7:0] chk, input logic [7:0] msk,
                                           input int dw, input int cw);
        logic [7:0] low_m, full_m, acc, res;
        logic       dpar, top;
        int         p;
        low_m  = 8'((1 << (cw - 1)) - 1);
        full_m = 8'((1 << cw) - 1);
        acc    = 8'h00;
        dpar   = 1'b0;
        p      = 3;
        for (int i = 0; i < dw; i++) begin
            while ((p & (p - 1)) == 0) p++;
            if (data[i]) begin
                acc  = acc ^ 8'(p);
                dpar = ~dpar;
            end
            p++;
        end
        acc = acc & low_m;
        if (!mode) begin
            top = dpar ^ (^acc);
            res = ((acc | (8'(top) << (cw - 1))) ^ msk) & full_m;
            return {2'b00, res};
        end
        acc = (acc ^ chk) & low_m;
        top = dpar ^ (^(chk & full_m));
        res = acc | (8'(top) << (cw - 1));
        return {top, (!top && acc != 8'h00), res};
    endfunction

    function automatic logic [15:0] obs_a();
        return {bus_a.out_tag, bus_a.out_ce, bus_a.out_ue, bus_a.out_chk};
    endfunction

    function automatic logic [15:0] obs_b();
        return {bus_b.out_tag, bus_b.out_ce, bus_b.out_ue, 1'b0, bus_b.out_chk};
    endfunction

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", name, obs, exp);
    endtask

    // ---------------- driver tasks ----------------
    task automatic set_rand_a(input logic [5:0] tag);
        logic [63:0] d;
        logic [9:0]  r;
        int          k, b1;
        d = {$urandom, $urandom};
        r = ref_ecc(1'b0, d, 8'h00, 8'h00, 64, 8);
        bus_a.in_mode = 1'($urandom_range(0, 1));
        bus_a.in_msk  = 8'($urandom);
        bus_a.in_chk  = r[7:0];
        k  = $urandom_range(0, 3);
        b1 = $urandom_range(0, 63);
        if (k == 1 || k == 2) d[b1] = ~d[b1];
        if (k == 2) d[(b1 + $urandom_range(1, 63)) % 64] ^= 1'b1;
        if (k == 3) bus_a.in_chk[$urandom_range(0, 7)] ^= 1'b1;
        bus_a.in_data = d;
        bus_a.in_tag  = tag;
        bus_a.in_vld  = 1'b1;
    endtask

    task automatic set_rand_b();
        logic [31:0] d;
        logic [9:0]  r;
        int          k, b1;
        d = $urandom;
        r = ref_ecc(1'b0, 64'(d), 8'h00, 8'h00, 32, 7);
        bus_b.in_mode = 1'($urandom_range(0, 1));
        bus_b.in_msk  = 7'($urandom);
        bus_b.in_chk  = r[6:0];
        k  = $urandom_range(0, 3);
        b1 = $urandom_range(0, 31);
        if (k == 1 || k == 2) d[b1] = ~d[b1];
        if (k == 2) d[(b1 + $urandom_range(1, 31)) % 32] ^= 1'b1;
        if (k == 3) bus_b.in_chk[$urandom_range(0, 6)] ^= 1'b1;
        bus_b.in_data = d;
        bus_b.in_tag  = 6'($urandom);
        bus_b.in_vld  = ($urandom_range(0, 3) != 0);
        bus_b.out_rdy = ($urandom_range(0, 3) != 0);
    endtask

    // One clock: sample handshakes just after the falling edge, update the
    // scoreboard, then advance to the next falling edge.
    task automatic tick();
        logic [9:0] r;
        #1;
        if (rst_l) begin
            if (a_hold) begin
                check("a_hold_vld", 32'(bus_a.out_vld), 32'd1);
                check("a_hold_data", 32'(obs_a()), 32'(a_prev));
            end
            if (b_hold) begin
                check("b_hold_vld", 32'(bus_b.out_vld), 32'd1);
                check("b_hold_data", 32'(obs_b()), 32'(b_prev));
            end
            if (bus_a.out_vld && bus_a.out_rdy) begin
                check("a_result_expected", 32'(exp_a_q.size() != 0), 32'd1);
                if (exp_a_q.size() != 0) check("a_result", 32'(obs_a()), 32'(exp_a_q.pop_front()));
            end
            if (bus_b.out_vld && bus_b.out_rdy) begin
                check("b_result_expected", 32'(exp_b_q.size() != 0), 32'd1);
                if (exp_b_q.size() != 0) check("b_result", 32'(obs_b()), 32'(exp_b_q.pop_front()));
            end
            a_hold = bus_a.out_vld && !bus_a.out_rdy;
            b_hold = bus_b.out_vld && !bus_b.out_rdy;
            a_prev = obs_a();
            b_prev = obs_b();
            a_acc  = bus_a.in_vld && bus_a.in_rdy;
            if (a_acc) begin
                r = use_dir ? dir_exp
                            : ref_ecc(bus_a.in_mode, bus_a.in_data, bus_a.in_chk, bus_a.in_msk, 64, 8);
                exp_a_q.push_back({bus_a.in_tag, r});
            end
            if (bus_b.in_vld && bus_b.in_rdy) begin
                r = ref_ecc(bus_b.in_mode, 64'(bus_b.in_data), 8'(bus_b.in_chk),
                            8'(bus_b.in_msk), 32, 7);
                exp_b_q.push_back({bus_b.in_tag, r});
            end
        end else begin
            exp_a_q.delete();
            exp_b_q.delete();
            a_hold = 1'b0;
            b_hold = 1'b0;
            a_acc  = 1'b0;
        end
        @(posedge clk);
        @(negedge clk);
        if (b_auto) set_rand_b();
    endtask

    task automatic drain();
        bus_a.in_vld  = 1'b0;
        bus_a.out_rdy = 1'b1;
        if (!b_auto) begin
            bus_b.in_vld  = 1'b0;
            bus_b.out_rdy = 1'b1;
        end
        for (int i = 0; i < 40 && (exp_a_q.size() != 0 || (!b_auto && exp_b_q.size() != 0)); i++)
            tick();
        check("a_drain_empty", 32'(exp_a_q.size()), 32'd0);
    endtask

    // ---------------- directed table (DATA_W=64) ----------------
    logic       t_mode [7];
    logic [7:0] t_data [7];
    logic [7:0] t_chk  [7];
    logic [7:0] t_msk  [7];
    logic [9:0] t_exp  [7];   // {ce, ue, out_chk}

    initial begin
        int  idx, cyc;
        logic saw_full;

        t_mode = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        t_data = '{8'h01, 8'h02, 8'h01, 8'h01, 8'h00, 8'h01, 8'h03};
        t_chk  = '{8'h00, 8'h00, 8'h00, 8'h83, 8'h83, 8'h80, 8'h83};
        t_msk  = '{8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00};
        t_exp  = '{10'h083, 10'h085, 10'h082, 10'h000, 10'h283, 10'h103, 10'h285};

        n_chk = 0; n_pass = 0;
        a_acc = 1'b0; a_hold = 1'b0; b_hold = 1'b0; a_prev = '0; b_prev = '0;
        use_dir = 1'b0; dir_exp = '0; b_auto = 1'b0;
        se = 1'b0;
        rst_l = 1'b0;
        bus_a.in_vld = 1'b0; bus_a.in_mode = 1'b0; bus_a.in_data = '0; bus_a.in_chk = '0;
        bus_a.in_msk = '0;   bus_a.in_tag = '0;    bus_a.out_rdy = 1'b1;
        bus_b.in_vld = 1'b0; bus_b.in_mode = 1'b0; bus_b.in_data = '0; bus_b.in_chk = '0;
        bus_b.in_msk = '0;   bus_b.in_tag = '0;    bus_b.out_rdy = 1'b1;

        // ---- reset state ----
        repeat (3) tick();
        rst_l = 1'b1;
        check("a_reset_out", 32'({bus_a.out_vld, obs_a()}), 32'd0);
        check("a_reset_rdy", 32'(bus_a.in_rdy), 32'd1);
        check("b_reset_out", 32'({bus_b.out_vld, obs_b()}), 32'd0);
        check("b_reset_rdy", 32'(bus_b.in_rdy), 32'd1);

        // ---- latency: zero word, GEN, no mask ----
        use_dir = 1'b1; dir_exp = 10'h000;
        bus_a.in_vld = 1'b1; bus_a.in_tag = 6'd1;
        bus_b.in_vld = 1'b1; bus_b.in_tag = 6'd1;
        tick();
        check("a_lat_accept", 32'(a_acc), 32'd1);
        check("a_lat_cycle1", 32'(bus_a.out_vld), 32'd0);
        check("b_lat_cycle1", 32'(bus_b.out_vld), 32'd1);
        bus_a.in_vld = 1'b0;
        bus_b.in_vld = 1'b0;
        tick();
        check("a_lat_cycle2", 32'(bus_a.out_vld), 32'd1);
        drain();

        // ---- directed GEN/CHK values, interleaved back to back ----
        for (int k = 0; k < 7; k++) begin
            bus_a.in_vld  = 1'b1;
            bus_a.in_mode = t_mode[k];
            bus_a.in_data = 64'(t_data[k]);
            bus_a.in_chk  = t_chk[k];
            bus_a.in_msk  = t_msk[k];
            bus_a.in_tag  = 6'(k + 2);
            dir_exp       = t_exp[k];
            tick();
            check("a_dir_accept", 32'(a_acc), 32'd1);
        end
        drain();
        use_dir = 1'b0;

        // ---- random stream of 10 ops with a 5-cycle output stall ----
        b_auto = 1'b1;
        idx = 0; cyc = 0; saw_full = 1'b0;
        while (idx < 10 && cyc < 200) begin
            set_rand_a(6'(idx));
            bus_a.out_rdy = !(cyc >= 3 && cyc < 8);
            tick();
            if (!a_acc) saw_full = 1'b1;
            if (a_acc) idx++;
            cyc++;
        end
        check("a_stream_count", 32'(idx), 32'd10);
        check("a_stall_backpressure", 32'(saw_full), 32'd1);
        drain();

        // ---- throughput: one op per cycle with no stall ----
        for (int k = 0; k < 12; k++) begin
            set_rand_a(6'(k + 20));
            bus_a.out_rdy = 1'b1;
            tick();
            check("a_throughput_accept", 32'(a_acc), 32'd1);
        end
        drain();

        // ---- reset with two ops in flight ----
        for (int k = 0; k < 2; k++) begin
            set_rand_a(6'(k + 40));
            tick();
        end
        set_rand_a(6'd50);           // presented during reset; must be ignored
        rst_l = 1'b0;
        tick();
        rst_l = 1'b1;
        bus_a.in_vld = 1'b0;
        check("a_midreset_out", 32'({bus_a.out_vld, obs_a()}), 32'd0);
        check("a_midreset_rdy", 32'(bus_a.in_rdy), 32'd1);
        check("b_midreset_vld", 32'(bus_b.out_vld), 32'd0);
        check("b_midreset_rdy", 32'(bus_b.in_rdy), 32'd1);

        use_dir = 1'b1; dir_exp = 10'h083;
        bus_a.in_vld = 1'b1; bus_a.in_mode = 1'b0; bus_a.in_data = 64'h1;
        bus_a.in_chk = 8'h00; bus_a.in_msk = 8'h00; bus_a.in_tag = 6'd33;
        tick();
        check("a_post_reset_accept", 32'(a_acc), 32'd1);
        drain();
        use_dir = 1'b0;

        // ---- longer random run with stalls on both engines ----
        for (int k = 0; k < 300; k++) begin
            if ($urandom_range(0, 3) != 0) set_rand_a(6'($urandom));
            else bus_a.in_vld = 1'b0;
            bus_a.out_rdy = ($urandom_range(0, 2) != 0);
            tick();
        end
        b_auto = 1'b0;
        drain();
        check("b_drain_empty", 32'(exp_b_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
